rect_cyl_seq: RTL
=================

Name: rect_cyl_seq

Overview:
- Shared rectangular-to-cylindrical conversion engine with two requesters (A, B).
- Round-robin arbitration between the requesters; one conversion in flight at a time.
- Computes r = floor(sqrt(x²+y²)) and theta = floor((x<<THETA_SHIFT)/y) with iterative restoring sqrt/divide, one bit per cycle.
- Sits between the tile's input capture logic and the result output register bank.

Parameters:
THETA_SHIFT, 4, fractional scale of theta; divide runs 8+THETA_SHIFT iterations
VERT_CODE, 90, theta code reported when y==0 and x!=0

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; low freezes all state
a_valid  input  1  requester A has operands
a_x  input  8  requester A x (unsigned)
a_y  input  8  requester A y (unsigned)
a_ready  output  1  A operands accepted this cycle when high with a_valid
b_valid  input  1  requester B has operands
b_x  input  8  requester B x
b_y  input  8  requester B y
b_ready  output  1  B operands accepted when high with b_valid
out_valid  output  1  result available
out_ready  input  1  consumer takes result
out_r  output  8  magnitude, saturated
out_theta  output  8  angle code, saturated
out_tag  output  1  0 = result for A, 1 = result for B
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; out_valid, out_r, out_theta, out_tag and busy are 0; last_grant = B, so A wins the first tie. Reset mid-operation aborts the operation; the result is discarded.
- ena low: no register changes; a_ready = b_ready = 0; out_valid holds its value; an out_ready handshake is ignored.
- States: IDLE -> SUM -> SQRT -> (DIV | DONE); DIV -> DONE; DONE -> IDLE.
- IDLE arbitration (combinational, only in IDLE with ena):
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - Only the granted requester's ready is high; ready is never high for an invalid requester.
- Accept edge: latch x, y and tag; last_grant <= tag; go to SUM.
- SUM (1 cycle): sum[16:0] = x*x + y*y registered; max value 130050.
- SQRT: 9 iterations of a restoring integer square root, one per cycle, on a 17-bit radicand giving a 9-bit root. r = root > 255 ? 255 : root[7:0].
- After SQRT:
  - x==0 and y==0: theta = 0, go to DONE.
  - y==0: theta = VERT_CODE, go to DONE.
  - Otherwise go to DIV.
- DIV: 8+THETA_SHIFT iterations of a restoring divide of {x, THETA_SHIFT'b0} by y, one per cycle. theta = quotient > 255 ? 255 : quotient[7:0].
- DONE: out_valid = 1; out_r, out_theta and out_tag are stable until the handshake.
  - out_valid & out_ready moves to IDLE; out_valid is 0 on the next cycle.
  - A new request can be accepted no earlier than the cycle after the output handshake (no overlap).
- Latency, accept edge to first cycle of out_valid, with THETA_SHIFT = 4:
  - 22 cycles general (1 + 9 + 12).
  - 10 cycles for y==0.
- Output registers are updated only on entry to DONE; they retain the last result while IDLE.
- a_x/a_y/b_x/b_y changes after acceptance have no effect.

Test Plan:
- A: x=3, y=4 -> out_r=5, out_theta=12, out_tag=0, out_valid exactly 22 cycles after accept.
- B: x=255, y=255 -> out_r=255 (sat from 360), out_theta=16, tag=1; then A x=255, y=1 -> out_r=255, out_theta=255 (sat from 4080).
- x=0, y=0 -> r=0, theta=0, latency 10; x=200, y=0 -> r=200, theta=90, latency 10.
- a_valid and b_valid held high continuously with distinct operands:
  - Grants alternate A, B, A, B starting with A after reset; tags match the grant order.
  - Ready is never high in a non-IDLE state.
- Backpressure and enable:
  - out_ready low 5 cycles in DONE: out_valid and outputs hold; a_ready/b_ready stay 0.
  - ena low 7 cycles mid-SQRT: the result is unchanged and latency grows by 7.
- rst_n pulsed low mid-DIV:
  - All outputs 0 immediately (asynchronous); busy drops.
  - The next tie grants A, and the next request completes correctly.

Source files
------------

// File: rtl/rect_cyl_if.sv
// Requester/consumer bundle for the shared rectangular-to-cylindrical engine.
interface rect_cyl_if;
  logic       a_valid;
  logic [7:0] a_x;
  logic [7:0] a_y;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_x;
  logic [7:0] b_y;
  logic       b_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_r;
  logic [7:0] out_theta;
  logic       out_tag;

  // Requesters and result consumer
  modport master (
    output a_valid, a_x, a_y, b_valid, b_x, b_y, out_ready,
    input  a_ready, b_ready, out_valid, out_r, out_theta, out_tag
  );

  // Conversion engine
  modport slave (
    input  a_valid, a_x, a_y, b_valid, b_x, b_y, out_ready,
    output a_ready, b_ready, out_valid, out_r, out_theta, out_tag
  );
endinterface

// File: rtl/rect_cyl_seq.sv
// Shared rect-to-cylindrical engine: round-robin over two requesters,
// bit-serial restoring sqrt for r and restoring divide for theta.
module rect_cyl_seq #(
  parameter int unsigned THETA_SHIFT = 4,
  parameter int unsigned VERT_CODE   = 90
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      ena,
  rect_cyl_if.slave bus,
  output logic      busy
);
  localparam int unsigned DW       = 8 + THETA_SHIFT;
  localparam int unsigned CNT_W    = $clog2(DW + 1);
  localparam int unsigned SQ_ITERS = 9;
  localparam int unsigned RAD_W    = 18;
  localparam int unsigned REM_W    = 11;

  typedef enum logic [2:0] {
    S_IDLE, S_SUM, S_SQRT, S_DIV, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [7:0]       x_q, x_d;
  logic [7:0]       y_q, y_d;
  logic             tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RAD_W-1:0] rad_q, rad_d;
  logic [REM_W-1:0] sq_rem_q, sq_rem_d;
  logic [8:0]       root_q, root_d;
  logic [DW-1:0]    dq_q, dq_d;
  logic [7:0]       dv_rem_q, dv_rem_d;
  logic             out_valid_d;
  logic [7:0]       out_r_d;
  logic [7:0]       out_theta_d;
  logic             out_tag_d;
  logic             busy_d;

  function automatic logic [7:0] sat_root(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

  // Arbitration: a tie goes to whichever requester was not served last
  logic idle_c, grant_a_c, grant_b_c;
  assign idle_c      = ena && (state_q == S_IDLE);
  assign grant_a_c   = idle_c && bus.a_valid && (!bus.b_valid || last_grant_q);
  assign grant_b_c   = idle_c && bus.b_valid && (!bus.a_valid || !last_grant_q);
  assign bus.a_ready = grant_a_c;
  assign bus.b_ready = grant_b_c;

  // Sum of squares of the latched operands
  logic [15:0] px_c, py_c;
  logic [16:0] sum_c;
  assign px_c  = 16'(x_q) * 16'(x_q);
  assign py_c  = 16'(y_q) * 16'(y_q);
  assign sum_c = 17'(px_c) + 17'(py_c);

  // One restoring square-root step: bring down two radicand bits, try 4*root+1
  logic [REM_W+1:0] sq_cand_c, sq_trial_c;
  logic             sq_ge_c;
  logic [REM_W-1:0] sq_rem_nx_c;
  logic [8:0]       root_nx_c;
  assign sq_cand_c   = {sq_rem_q, rad_q[RAD_W-1 -: 2]};
  assign sq_trial_c  = (REM_W+2)'({root_q, 2'b01});
  assign sq_ge_c     = sq_cand_c >= sq_trial_c;
  assign sq_rem_nx_c = sq_ge_c ? REM_W'(sq_cand_c - sq_trial_c) : REM_W'(sq_cand_c);
  assign root_nx_c   = {root_q[7:0], sq_ge_c};

  // One restoring divide step; dq holds remaining dividend bits and builds the quotient
  logic [8:0]    dv_cand_c;
  logic          dv_ge_c;
  logic [7:0]    dv_rem_nx_c;
  logic [DW-1:0] dq_nx_c;
  logic [7:0]    theta_sat_c;
  assign dv_cand_c   = {dv_rem_q, dq_q[DW-1]};
  assign dv_ge_c     = dv_cand_c >= {1'b0, y_q};
  assign dv_rem_nx_c = dv_ge_c ? 8'(dv_cand_c - {1'b0, y_q}) : 8'(dv_cand_c);
  assign dq_nx_c     = {dq_q[DW-2:0], dv_ge_c};
  assign theta_sat_c = (dq_nx_c > DW'(255)) ? 8'hFF : dq_nx_c[7:0];

  // Next-state, datapath and output-register values
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    x_d          = x_q;
    y_d          = y_q;
    tag_d        = tag_q;
    cnt_d        = cnt_q;
    rad_d        = rad_q;
    sq_rem_d     = sq_rem_q;
    root_d       = root_q;
    dq_d         = dq_q;
    dv_rem_d     = dv_rem_q;
    out_r_d      = bus.out_r;
    out_theta_d  = bus.out_theta;
    out_tag_d    = bus.out_tag;

    unique case (state_q)
      S_IDLE: begin
        if (grant_a_c || grant_b_c) begin
          x_d          = grant_b_c ? bus.b_x : bus.a_x;
          y_d          = grant_b_c ? bus.b_y : bus.a_y;
          tag_d        = grant_b_c;
          last_grant_d = grant_b_c;
          state_d      = S_SUM;
        end
      end
      S_SUM: begin
        rad_d    = {1'b0, sum_c};
        sq_rem_d = '0;
        root_d   = '0;
        cnt_d    = '0;
        state_d  = S_SQRT;
      end
      S_SQRT: begin
        rad_d    = {rad_q[RAD_W-3:0], 2'b00};
        sq_rem_d = sq_rem_nx_c;
        root_d   = root_nx_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SQ_ITERS - 1)) begin
          cnt_d = '0;
          if (y_q == 8'd0) begin
            out_r_d     = sat_root(root_nx_c);
            out_theta_d = (x_q == 8'd0) ? 8'd0 : 8'(VERT_CODE);
            out_tag_d   = tag_q;
            state_d     = S_DONE;
          end else begin
            dq_d     = DW'(x_q) << THETA_SHIFT;
            dv_rem_d = '0;
            state_d  = S_DIV;
          end
        end
      end
      S_DIV: begin
        dq_d     = dq_nx_c;
        dv_rem_d = dv_rem_nx_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DW - 1)) begin
          cnt_d       = '0;
          out_r_d     = sat_root(root_q);
          out_theta_d = theta_sat_c;
          out_tag_d   = tag_q;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and datapath registers; ena low freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      tag_q         <= 1'b0;
      cnt_q         <= '0;
      rad_q         <= '0;
      sq_rem_q      <= '0;
      root_q        <= '0;
      dq_q          <= '0;
      dv_rem_q      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_r     <= '0;
      bus.out_theta <= '0;
      bus.out_tag   <= 1'b0;
      busy          <= 1'b0;
    end else if (ena) begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      x_q           <= x_d;
      y_q           <= y_d;
      tag_q         <= tag_d;
      cnt_q         <= cnt_d;
      rad_q         <= rad_d;
      sq_rem_q      <= sq_rem_d;
      root_q        <= root_d;
      dq_q          <= dq_d;
      dv_rem_q      <= dv_rem_d;
      bus.out_valid <= out_valid_d;
      bus.out_r     <= out_r_d;
      bus.out_theta <= out_theta_d;
      bus.out_tag   <= out_tag_d;
      busy          <= busy_d;
    end
  end
endmodule
